// File: rtl/nanorv32_code_arbiter.sv
// Arbitrates the single-port code RAM between instruction fetch and code-space
// data accesses. Define NANORV32_CODE_WRITE_EN to allow data writes; otherwise ROM mode.
module nanorv32_code_arbiter #(
    parameter int AW              = 15,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_ack,
    output logic [31:0]   fetch_rdata,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [31:0]   data_addr,
    input  logic [3:0]    data_bytesel,
    input  logic [31:0]   data_wdata,
    output logic          data_ack,
    output logic [31:0]   data_rdata,
    output logic          data_wr_err,
    output logic [AW-3:0] ram_addr,
    output logic [3:0]    ram_we,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    localparam logic [7:0] STREAK_MAX = 8'(MAX_DATA_STREAK);

    owner_e     owner_q, owner_d;
    logic [7:0] streak_q, streak_d;
    logic       grant_data;
    logic       grant_fetch;
    logic       data_write;

    // Grants are forced off while reset is held so no access leaks out.
    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if (rst_n) begin
            grant_data  = data_req && !(fetch_req && (streak_q == STREAK_MAX));
            grant_fetch = fetch_req && !grant_data;
        end
        data_write = grant_data && data_we;
    end

    always_comb begin
        owner_d  = OWN_NONE;
        streak_d = streak_q;
        if (grant_fetch) begin
            owner_d = OWN_FETCH;
        end else if (grant_data && !data_we) begin
            owner_d = OWN_DATA;
        end
        if (!fetch_req || grant_fetch) begin
            streak_d = 8'd0;
        end else if (grant_data && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            streak_q <= 8'd0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        ram_addr    = grant_data ? data_addr[AW-1:2] : fetch_addr[AW-1:2];
        ram_din     = data_wdata;
        fetch_rdata = ram_dout;
        data_rdata  = ram_dout;
        fetch_ack   = (owner_q == OWN_FETCH);
        data_ack    = (owner_q == OWN_DATA) || data_write;
`ifdef NANORV32_CODE_WRITE_EN
        ram_we      = data_write ? data_bytesel : 4'b0000;
        data_wr_err = 1'b0;
`else
        ram_we      = 4'b0000;
        data_wr_err = data_write;
`endif
    end

`ifdef NANORV32_CODE_WRITE_EN
    logic unused_bits;
    assign unused_bits = ^{fetch_addr[31:AW], fetch_addr[1:0],
                           data_addr[31:AW], data_addr[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{fetch_addr[31:AW], fetch_addr[1:0],
                           data_addr[31:AW], data_addr[1:0], data_bytesel};
`endif

`ifndef SYNTHESIS
    // A requester that is waiting (not granted) must keep its request up.
    assert property (@(posedge clk) disable iff (!rst_n)
                     (fetch_req && !grant_fetch) |=> fetch_req);
    assert property (@(posedge clk) disable iff (!rst_n)
                     (data_req && !grant_data) |=> data_req);
`endif

endmodule

// File: tb/tb_nanorv32_code_arbiter.sv
// Table-driven, scoreboarded bench for nanorv32_code_arbiter with a behavioural
// code RAM; honours NANORV32_CODE_WRITE_EN for the expected write behaviour.
module tb_nanorv32_code_arbiter;

    localparam int AW = 15;
    localparam int NWORDS = 1 << (AW - 2);
`ifdef NANORV32_CODE_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    localparam logic [1:0] G_NONE  = 2'd0;
    localparam logic [1:0] G_FETCH = 2'd1;
    localparam logic [1:0] G_DATA  = 2'd2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_addr = '0;
    logic          fetch_ack;
    logic [31:0]   fetch_rdata;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [31:0]   data_addr = '0;
    logic [3:0]    data_bytesel = '0;
    logic [31:0]   data_wdata = '0;
    logic          data_ack;
    logic [31:0]   data_rdata;
    logic          data_wr_err;
    logic [AW-3:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout = '0;

    int total = 0;
    int bad = 0;

    nanorv32_code_arbiter #(.AW(AW), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_bytesel(data_bytesel), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata), .data_wr_err(data_wr_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(int i);
        logic [15:0] lo;
        lo = 16'(i);
        return {16'hC0DE ^ lo, lo};
    endfunction

    // Behavioural byte-write RAM with one-cycle read latency.
    logic [31:0] ram_mem [0:NWORDS-1];
    initial begin
        for (int i = 0; i < NWORDS; i++) ram_mem[i] = initWord(i);
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= ram_mem[ram_addr];
    end

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [3:0]  bsel;
        logic [31:0] wdata;
        logic [1:0]  exp_grant;
    } vec_t;

    typedef struct {
        logic        is_fetch;
        logic [31:0] word;
    } ack_t;

    vec_t        vecs[$];
    ack_t        sb[$];
    logic [31:0] shadow [0:NWORDS-1];

    function automatic vec_t mkVec(logic fr, logic [31:0] fa, logic dr, logic dw,
                                   logic [31:0] da, logic [3:0] bs, logic [31:0] wd,
                                   logic [1:0] g);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.bsel = bs; v.wdata = wd; v.exp_grant = g;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        fetch_req    = v.f_req;
        fetch_addr   = v.f_addr;
        data_req     = v.d_req;
        data_we      = v.d_we;
        data_addr    = v.d_addr;
        data_bytesel = v.bsel;
        data_wdata   = v.wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        exp_fack, exp_dack, wr;
        logic [31:0] exp_word, ga, merged;
        logic [12:0] widx;

        for (int i = 0; i < NWORDS; i++) shadow[i] = initWord(i);

        // fetch stream
        vecs.push_back(mkVec(1, 32'h000, 0, 0, 32'h000, 4'h0, 32'h0, G_FETCH));
        vecs.push_back(mkVec(1, 32'h004, 0, 0, 32'h000, 4'h0, 32'h0, G_FETCH));
        vecs.push_back(mkVec(1, 32'h008, 0, 0, 32'h000, 4'h0, 32'h0, G_FETCH));
        vecs.push_back(mkVec(0, 32'h008, 0, 0, 32'h000, 4'h0, 32'h0, G_NONE));
        // data beats fetch, fetch follows
        vecs.push_back(mkVec(1, 32'h020, 1, 0, 32'h010, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h020, 0, 0, 32'h010, 4'h0, 32'h0, G_FETCH));
        vecs.push_back(mkVec(0, 32'h020, 0, 0, 32'h000, 4'h0, 32'h0, G_NONE));
        // starvation guard: 4 data grants then one fetch, twice
        vecs.push_back(mkVec(1, 32'h200, 1, 0, 32'h100, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h200, 1, 0, 32'h104, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h200, 1, 0, 32'h108, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h200, 1, 0, 32'h10C, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h200, 1, 0, 32'h110, 4'h0, 32'h0, G_FETCH));
        vecs.push_back(mkVec(1, 32'h204, 1, 0, 32'h110, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h204, 1, 0, 32'h114, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h204, 1, 0, 32'h118, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h204, 1, 0, 32'h11C, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h204, 1, 0, 32'h120, 4'h0, 32'h0, G_FETCH));
        vecs.push_back(mkVec(0, 32'h204, 1, 0, 32'h120, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(0, 32'h000, 0, 0, 32'h000, 4'h0, 32'h0, G_NONE));
        // partial write then readback
        vecs.push_back(mkVec(0, 32'h000, 1, 1, 32'h040, 4'b0011, 32'hAABBCCDD, G_DATA));
        vecs.push_back(mkVec(0, 32'h000, 1, 0, 32'h040, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(0, 32'h000, 0, 0, 32'h000, 4'h0, 32'h0, G_NONE));
        // writes count toward the streak
        vecs.push_back(mkVec(1, 32'h300, 1, 1, 32'h044, 4'b1100, 32'h11223344, G_DATA));
        vecs.push_back(mkVec(1, 32'h300, 1, 1, 32'h048, 4'b1111, 32'h55667788, G_DATA));
        vecs.push_back(mkVec(1, 32'h300, 1, 0, 32'h044, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h300, 1, 0, 32'h048, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(1, 32'h300, 1, 0, 32'h04C, 4'h0, 32'h0, G_FETCH));
        vecs.push_back(mkVec(0, 32'h300, 1, 0, 32'h04C, 4'h0, 32'h0, G_DATA));
        vecs.push_back(mkVec(0, 32'h000, 0, 0, 32'h000, 4'h0, 32'h0, G_NONE));

        // reset state
        @(negedge clk);
        #1;
        checkOutput("reset fetch_ack", 32'(fetch_ack), 32'd0);
        checkOutput("reset data_ack", 32'(data_ack), 32'd0);
        checkOutput("reset data_wr_err", 32'(data_wr_err), 32'd0);
        checkOutput("reset ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            applyStimulus(vecs[k]);
            #1;
            exp_fack = 1'b0;
            exp_dack = 1'b0;
            exp_word = '0;
            if (sb.size() > 0) begin
                ack_t e;
                e = sb.pop_front();
                exp_fack = e.is_fetch;
                exp_dack = !e.is_fetch;
                exp_word = e.word;
            end
            wr = (vecs[k].exp_grant == G_DATA) && vecs[k].d_we;
            ga = (vecs[k].exp_grant == G_DATA) ? vecs[k].d_addr : vecs[k].f_addr;
            widx = ga[14:2];
            checkOutput($sformatf("v%0d fetch_ack", k), 32'(fetch_ack), 32'(exp_fack));
            checkOutput($sformatf("v%0d data_ack", k), 32'(data_ack), 32'(exp_dack | wr));
            if (exp_fack) checkOutput($sformatf("v%0d fetch_rdata", k), fetch_rdata, exp_word);
            if (exp_dack) checkOutput($sformatf("v%0d data_rdata", k), data_rdata, exp_word);
            checkOutput($sformatf("v%0d ram_addr", k), 32'(ram_addr), 32'(widx));
            checkOutput($sformatf("v%0d ram_we", k), 32'(ram_we),
                        32'((wr && WRITE_EN) ? vecs[k].bsel : 4'b0000));
            checkOutput($sformatf("v%0d data_wr_err", k), 32'(data_wr_err),
                        32'(wr && !WRITE_EN));
            if (vecs[k].exp_grant != G_NONE && !wr) begin
                ack_t n;
                n.is_fetch = (vecs[k].exp_grant == G_FETCH);
                n.word = shadow[widx];
                sb.push_back(n);
            end
            if (wr && WRITE_EN) begin
                merged = shadow[widx];
                for (int b = 0; b < 4; b++)
                    if (vecs[k].bsel[b]) merged[8*b +: 8] = vecs[k].wdata[8*b +: 8];
                shadow[widx] = merged;
            end
        end
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

        // reset right after a fetch grant aborts the access
        @(negedge clk);
        applyStimulus(mkVec(1, 32'h008, 0, 0, 32'h0, 4'h0, 32'h0, G_FETCH));
        #1;
        checkOutput("pre-reset ram_addr", 32'(ram_addr), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(mkVec(0, 32'h000, 1, 1, 32'h040, 4'hF, 32'hDEADBEEF, G_NONE));
        #1;
        checkOutput("in-reset fetch_ack", 32'(fetch_ack), 32'd0);
        checkOutput("in-reset data_ack", 32'(data_ack), 32'd0);
        checkOutput("in-reset data_wr_err", 32'(data_wr_err), 32'd0);
        checkOutput("in-reset ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        applyStimulus(mkVec(0, 32'h000, 0, 0, 32'h000, 4'h0, 32'h0, G_NONE));
        rst_n = 1'b1;
        #1;
        checkOutput("post-release fetch_ack", 32'(fetch_ack), 32'd0);
        checkOutput("post-release data_ack", 32'(data_ack), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("no late fetch_ack", 32'(fetch_ack), 32'd0);
        applyStimulus(mkVec(1, 32'h00C, 0, 0, 32'h000, 4'h0, 32'h0, G_FETCH));
        #1;
        checkOutput("after-reset ram_addr", 32'(ram_addr), 32'd3);
        @(negedge clk);
        applyStimulus(mkVec(0, 32'h00C, 0, 0, 32'h000, 4'h0, 32'h0, G_NONE));
        #1;
        checkOutput("after-reset fetch_ack", 32'(fetch_ack), 32'd1);
        checkOutput("after-reset fetch_rdata", fetch_rdata, shadow[3]);
        @(negedge clk);
        #1;
        checkOutput("after-reset ack pulse", 32'(fetch_ack), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
